switch_debounce_step: RTL and testbench

//  Consumes the sampled, clock-domain-safe switch level plus its sample strobe
//  and produces a debounced level, one-cycle press/release pulses, and a

---
 rtl/switch_debounce_step_pkg.sv | 17 +
 rtl/switch_debounce_step.sv | 172 +++++++++++++++++
 tb/tb_switch_debounce_step.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/switch_debounce_step_pkg.sv
// ---------------------------------------------------------------------------
// switch_debounce_step_pkg
// Shared definitions for the push-button debounce / single-step blocks.
// The state encodings are fixed 3-bit values so other button blocks and
// debug logic can decode the state register consistently.
// ---------------------------------------------------------------------------
package switch_debounce_step_pkg;

  typedef enum logic [2:0] {
    S_LOW     = 3'd0,
    S_TO_HIGH = 3'd1,
    S_HIGH    = 3'd2,
    S_REPEAT  = 3'd3,
    S_TO_LOW  = 3'd4
  } state_t;

endpackage

// File: rtl/switch_debounce_step.sv
// ---------------------------------------------------------------------------
// switch_debounce_step
// Debounces an already-synchronised switch level, evaluated only on a sample
// strobe, and produces a debounced level, one-cycle press/release pulses and
// a single-step pulse that optionally auto-repeats while the button is held.
//
// Ports
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_switch     synchronised switch level
//   i_sample     one-cycle sample strobe; state only advances on it
//   i_repeat_en  enables auto-repeat while held (sampled on i_sample)
//   o_level      debounced level
//   o_press      one-cycle pulse on accepted 0->1
//   o_release    one-cycle pulse on accepted 1->0
//   o_step       one-cycle pulse on press and on each auto-repeat
// ---------------------------------------------------------------------------
module switch_debounce_step
  import switch_debounce_step_pkg::*;
#(
  parameter int STABLE_COUNT = 4,
  parameter int HOLD_COUNT   = 250,
  parameter int REPEAT_COUNT = 50,
  parameter int CNT_W        = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_switch,
  input  logic i_sample,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_step
);

  localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] HOLD_L   = CNT_W'(HOLD_COUNT);
  localparam logic [CNT_W-1:0] REPEAT_L = CNT_W'(REPEAT_COUNT);
  localparam logic [CNT_W-1:0] ONE_L    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             level_nxt, press_nxt, release_nxt, step_nxt;

  assign cnt_inc = cnt + ONE_L;

  // Next-state, counter and event decode. Everything holds unless the
  // sample strobe is present; each compare clears the counter before it can
  // reach the top of its range, so it never wraps.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = o_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    step_nxt    = 1'b0;

    if (i_sample) begin
      unique case (state)
        S_LOW: begin
          if (i_switch) begin
            state_nxt = S_TO_HIGH;
            cnt_nxt   = ONE_L;
          end else begin
            cnt_nxt = '0;
          end
        end

        S_TO_HIGH: begin
          if (!i_switch) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
          end else if (cnt_inc == STABLE_L) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
            step_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        S_HIGH: begin
          if (!i_switch) begin
            state_nxt = S_TO_LOW;
            cnt_nxt   = ONE_L;
          end else if (i_repeat_en && (cnt_inc == HOLD_L)) begin
            state_nxt = S_REPEAT;
            cnt_nxt   = '0;
            step_nxt  = 1'b1;
          end else if (i_repeat_en) begin
            cnt_nxt = cnt_inc;
          end else begin
            cnt_nxt = '0;
          end
        end

        S_REPEAT: begin
          if (!i_switch) begin
            state_nxt = S_TO_LOW;
            cnt_nxt   = ONE_L;
          end else if (!i_repeat_en) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
          end else if (cnt_inc == REPEAT_L) begin
            cnt_nxt  = '0;
            step_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        // A bounce back high only restores the held state; the hold timer
        // restarts and no fresh press/step is produced.
        S_TO_LOW: begin
          if (i_switch) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
          end else if (cnt_inc == STABLE_L) begin
            state_nxt   = S_LOW;
            cnt_nxt     = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        default: begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end
      endcase
    end else if (!(state inside {S_LOW, S_TO_HIGH, S_HIGH, S_REPEAT, S_TO_LOW})) begin
      // Corrupted encodings recover on the next clock even without a strobe.
      state_nxt = S_LOW;
      cnt_nxt   = '0;
      level_nxt = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered outputs; pulses last exactly one cycle because their decode
  // defaults to 0 on every cycle that does not make a decision.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_step    <= 1'b0;
    end else begin
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      o_step    <= step_nxt;
    end
  end

endmodule

// File: tb/tb_switch_debounce_step.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_step
// Self-checking bench for switch_debounce_step (STABLE=4, HOLD=8, REPEAT=3).
// A run-length reference model predicts every output each clock; a vector
// table and hand-written sequences pin down the documented corner cases.
// ---------------------------------------------------------------------------
module tb_switch_debounce_step;

  localparam int STABLE = 4;
  localparam int HOLD   = 8;
  localparam int REPEAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sw;
  logic sample;
  logic repeat_en;
  logic level, press, release_p, step;

  int tests = 0;
  int fails = 0;

  // Reference model state: debounced level, run of samples disagreeing with
  // it, samples counted toward the next step, and whether repeating.
  logic m_level;
  int   m_diff;
  int   m_hold;
  logic m_rep;
  logic e_press, e_release, e_step;

  typedef struct {
    logic sw;
    logic en;
    logic lvl;
    logic prs;
    logic rel;
    logic stp;
  } vec_t;

  vec_t vecs[$];

  switch_debounce_step #(
    .STABLE_COUNT (STABLE),
    .HOLD_COUNT   (HOLD),
    .REPEAT_COUNT (REPEAT),
    .CNT_W        (8)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_switch    (sw),
    .i_sample    (sample),
    .i_repeat_en (repeat_en),
    .o_level     (level),
    .o_press     (press),
    .o_release   (release_p),
    .o_step      (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  // Advance the behavioural model by one clock with the given inputs.
  task automatic model_step(input logic s, input logic en, input logic smp);
    logic was_bouncing;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_step    = 1'b0;
    if (!rst_n) begin
      m_level = 1'b0;
      m_diff  = 0;
      m_hold  = 0;
      m_rep   = 1'b0;
      return;
    end
    if (!smp) return;
    if (s != m_level) begin
      m_diff++;
      if (m_diff == STABLE) begin
        m_level = s;
        m_diff  = 0;
        m_hold  = 0;
        m_rep   = 1'b0;
        if (s) begin
          e_press = 1'b1;
          e_step  = 1'b1;
        end else begin
          e_release = 1'b1;
        end
      end
    end else begin
      was_bouncing = (m_diff != 0);
      m_diff = 0;
      if (m_level) begin
        if (was_bouncing || !en) begin
          m_hold = 0;
          m_rep  = 1'b0;
        end else begin
          m_hold++;
          if (m_hold == (m_rep ? REPEAT : HOLD)) begin
            e_step = 1'b1;
            m_rep  = 1'b1;
            m_hold = 0;
          end
        end
      end
    end
  endtask

  // Drive one clock of inputs, then compare all outputs 1 time unit after
  // the rising edge against the model.
  task automatic applyStimulus(input logic s, input logic en, input logic smp);
    sw        = s;
    repeat_en = en;
    sample    = smp;
    model_step(s, en, smp);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("level",   level,             m_level);
    check("press",   press,             e_press);
    check("release", release_p,         e_release);
    check("step",    step,              e_step);
    check("press_release_excl", press & release_p, 1'b0);
  endtask

  // One sample period: four idle clocks, then the strobe clock.
  task automatic do_sample(input logic s, input logic en);
    repeat (4) applyStimulus(s, en, 1'b0);
    applyStimulus(s, en, 1'b1);
  endtask

  task automatic add_vec(input logic s, input logic en, input logic l,
                         input logic p, input logic r, input logic st);
    vec_t v;
    v.sw = s; v.en = en; v.lvl = l; v.prs = p; v.rel = r; v.stp = st;
    vecs.push_back(v);
  endtask

  initial begin
    logic rs, re;

    rst_n     = 1'b0;
    sw        = 1'b1;
    sample    = 1'b0;
    repeat_en = 1'b0;
    #2;

    // Reset held low for 3 cycles with the switch high and strobes present.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_sample(1'b1, 1'b0);
    check("reset_then_press", m_level, 1'b1);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Bounce then stable press
    add_vec(1,1, 0,0,0,0); add_vec(0,1, 0,0,0,0); add_vec(1,1, 0,0,0,0);
    add_vec(1,1, 0,0,0,0); add_vec(0,1, 0,0,0,0);
    add_vec(1,1, 0,0,0,0); add_vec(1,1, 0,0,0,0); add_vec(1,1, 0,0,0,0);
    add_vec(1,1, 1,1,0,1);
    // Hold with repeat: step after 8 samples, then every 3
    for (int i = 0; i < 7; i++) add_vec(1,1, 1,0,0,0);
    add_vec(1,1, 1,0,0,1);
    add_vec(1,1, 1,0,0,0); add_vec(1,1, 1,0,0,0); add_vec(1,1, 1,0,0,1);
    // Release with a glitch high on the second low sample
    add_vec(0,1, 1,0,0,0); add_vec(1,1, 1,0,0,0);
    add_vec(0,1, 1,0,0,0); add_vec(0,1, 1,0,0,0); add_vec(0,1, 1,0,0,0);
    add_vec(0,1, 0,0,1,0);
    // Repeat disabled: only the press step
    add_vec(1,0, 0,0,0,0); add_vec(1,0, 0,0,0,0); add_vec(1,0, 0,0,0,0);
    add_vec(1,0, 1,1,0,1);
    for (int i = 0; i < 10; i++) add_vec(1,0, 1,0,0,0);
    add_vec(0,0, 1,0,0,0); add_vec(0,0, 1,0,0,0); add_vec(0,0, 1,0,0,0);
    add_vec(0,0, 0,0,1,0);

    foreach (vecs[i]) begin
      do_sample(vecs[i].sw, vecs[i].en);
      check($sformatf("vec%0d_level", i),   level,     vecs[i].lvl);
      check($sformatf("vec%0d_press", i),   press,     vecs[i].prs);
      check($sformatf("vec%0d_release", i), release_p, vecs[i].rel);
      check($sformatf("vec%0d_step", i),    step,      vecs[i].stp);
    end

    // Reach auto-repeat, then reset asynchronously mid-cycle.
    for (int i = 0; i < 13; i++) do_sample(1'b1, 1'b1);
    check("in_repeat_level", level, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level",   level,     1'b0);
    check("async_rst_press",   press,     1'b0);
    check("async_rst_release", release_p, 1'b0);
    check("async_rst_step",    step,      1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) do_sample(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_sample(1'b1, 1'b0);
    check("post_rst_not_yet", level, 1'b0);
    do_sample(1'b1, 1'b0);
    check("post_rst_press", press, 1'b1);

    // Randomised run against the model, with back-to-back strobes allowed.
    rs = 1'b1;
    re = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic smp;
      smp = ($urandom_range(0, 2) == 0);
      if (smp && ($urandom_range(0, 5) == 0)) rs = ~rs;
      if ($urandom_range(0, 79) == 0) re = ~re;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      applyStimulus(rs, re, smp);
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
